cluster_rate_monitor: RTL and testbench
=======================================

// Module: cluster_rate_monitor
// PURPOSE
//  Sits directly downstream of the cluster counter. Consumes the per-BX cluster
//  count and its overflow flag (overflow = count > 8) in the clock4x domain.
//  Accumulates statistics over a programmable window of sampled BXs and presents
//  one snapshot per window to slow control through a valid/ack handshake.
//  Statistics: cluster sum, peak count, overflow-BX count, empty-BX count.
// PARAMETERS
//  CNT_W      8      width of cnt_in (matches the upstream counter)
//  WIN_W      16     width of window_len and of the sample counter
//  SUM_W      24     width of the cluster-sum accumulator and output
//  EVT_W      16     width of the overflow-BX and empty-BX counters
// PORTS
//  clock4x       in   1      4x LHC clock; all logic on the rising edge
//  reset         in   1      synchronous, active-high
//  enable        in   1      run/stop; level-sensitive
//  window_len    in   WIN_W  samples per window; sampled only on IDLE->RUN; 0 is treated as 1
//  sample_en     in   1      cnt_in/overflow_in valid this cycle (one pulse per BX)
//  cnt_in        in   CNT_W  clusters in this BX
//  overflow_in   in   1      upstream overflow flag for this BX
//  stats_valid   out  1      snapshot outputs valid; held until acked
//  stats_ack     in   1      consumer accepts snapshot (stats_valid & stats_ack)
//  stat_sum      out  SUM_W  sum of cnt_in over the window, saturating
//  stat_max      out  CNT_W  largest cnt_in seen in the window
//  stat_ovf      out  EVT_W  samples with overflow_in=1, saturating
//  stat_empty    out  EVT_W  samples with cnt_in==0, saturating
//  stat_lost     out  1      sticky: a snapshot was overwritten before being acked
//  running       out  1      FSM is in RUN
// BEHAVIOUR
//  Reset: FSM=IDLE; all accumulators, sample counter, and outputs = 0.
//  The FSM has two states.
//   IDLE: accumulators are held at 0. If enable=1, latch len=max(window_len,1) and go to RUN.
//   RUN:  if enable=0, go to IDLE next cycle and discard the partial window. A snapshot
//         that is already pending stays valid until acked.
//  Accumulation occurs in RUN on each cycle with sample_en=1.
//   sum += cnt_in, clamping at 2^SUM_W-1.
//   max = max(max, cnt_in).
//   ovf += overflow_in, clamping at all-ones. empty += (cnt_in==0), clamping at all-ones.
//   The sample counter increments.
//  sample_en is ignored in IDLE and on the cycle of the IDLE->RUN transition.
//  Window close: the sample accepted when sample_counter == len-1 is included in the window.
//   On the next cycle, stat_* hold the totals including that sample and stats_valid=1.
//   Latency from the last sample to stats_valid is 1 cycle.
//   In that same close cycle, the accumulators and sample counter restart from 0 with no
//   dead time, so a sample_en on the next cycle counts toward the new window.
//  Handshake: stats_valid falls on the cycle after stats_valid & stats_ack.
//   If a new window closes on the same cycle as an ack, the new snapshot loads and
//   stats_valid stays 1.
//   If a window closes while stats_valid=1 and there is no ack, stat_* are overwritten,
//   stats_valid stays 1, and stat_lost is set.
//  stat_lost clears only on reset, or on an IDLE->RUN transition.
//  Changes to window_len during RUN have no effect until the next IDLE->RUN.
//  reset during RUN aborts immediately. All state returns to reset values on the next
//  edge, regardless of stats_valid.
//  running = (state == RUN).
// TESTING
//  T1: len=4; cnt_in=3,0,9(ovf),2 on 4 sample_en pulses -> 1 cycle later stats_valid=1,
//      sum=14, max=9, ovf=1, empty=1.
//  T2: len=2; samples continue every 4th cycle with no ack -> 2nd close overwrites the
//      snapshot and stat_lost=1; ack -> stats_valid=0 on the next cycle.
//  T3: SUM_W=8; len=40; cnt_in=8 per sample (320>255) -> sum=255 (saturated), max=8.
//  T4: drop enable after 3 of len=5 samples -> no stats_valid; re-enable and send 5 samples
//      of 1 -> sum=5 (partial window discarded), stat_lost=0.
//  T5: ack asserted on the same cycle a new window closes -> stats_valid stays 1 and the
//      new values are shown; window_len=0 -> every sample closes a window.
//  T6: assert reset mid-window with stats_valid=1 -> all outputs 0 on the next edge;
//      running=0.

Source files
------------

// File: rtl/cluster_rate_monitor.sv
// Windowed cluster-rate statistics for the clock4x domain: accumulates sum, peak,
// overflow-BX and empty-BX counts per window and hands each snapshot to slow control.
module cluster_rate_monitor #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 16,
  parameter int SUM_W = 24,
  parameter int EVT_W = 16
) (
  input  logic             clock4x,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIN_W-1:0] window_len,
  input  logic             sample_en,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             overflow_in,
  output logic             stats_valid,
  input  logic             stats_ack,
  output logic [SUM_W-1:0] stat_sum,
  output logic [CNT_W-1:0] stat_max,
  output logic [EVT_W-1:0] stat_ovf,
  output logic [EVT_W-1:0] stat_empty,
  output logic             stat_lost,
  output logic             running
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIN_W-1:0] len;
  logic [WIN_W-1:0] sample_cnt;
  logic [SUM_W-1:0] acc_sum;
  logic [CNT_W-1:0] acc_max;
  logic [EVT_W-1:0] acc_ovf;
  logic [EVT_W-1:0] acc_empty;

  logic [SUM_W:0]   sum_ext;
  logic [SUM_W-1:0] nxt_sum;
  logic [CNT_W-1:0] nxt_max;
  logic [EVT_W-1:0] nxt_ovf;
  logic [EVT_W-1:0] nxt_empty;
  logic             win_close;

  // Running totals including the current sample, each clamped at all-ones.
  always_comb begin
    sum_ext   = {1'b0, acc_sum} + {{(SUM_W + 1 - CNT_W){1'b0}}, cnt_in};
    nxt_sum   = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
    nxt_max   = (cnt_in > acc_max) ? cnt_in : acc_max;
    nxt_ovf   = (overflow_in && (acc_ovf != '1)) ? acc_ovf + EVT_W'(1) : acc_ovf;
    nxt_empty = ((cnt_in == '0) && (acc_empty != '1)) ? acc_empty + EVT_W'(1) : acc_empty;
    win_close = sample_en && (sample_cnt == len - WIN_W'(1));
  end

  assign running = (state == RUN);

  // NOTE: reset is synchronous, so it is only seen inside the clocked block;
  // every register, including the snapshot outputs, returns to zero on that edge.
  always_ff @(posedge clock4x) begin
    if (reset) begin
      state       <= IDLE;
      len         <= '0;
      sample_cnt  <= '0;
      acc_sum     <= '0;
      acc_max     <= '0;
      acc_ovf     <= '0;
      acc_empty   <= '0;
      stats_valid <= 1'b0;
      stat_sum    <= '0;
      stat_max    <= '0;
      stat_ovf    <= '0;
      stat_empty  <= '0;
      stat_lost   <= 1'b0;
    end else begin
      // A window close below overrides this and keeps stats_valid high.
      if (stats_valid && stats_ack) stats_valid <= 1'b0;

      case (state)
        IDLE: begin
          sample_cnt <= '0;
          acc_sum    <= '0;
          acc_max    <= '0;
          acc_ovf    <= '0;
          acc_empty  <= '0;
          if (enable) begin
            len       <= (window_len == '0) ? WIN_W'(1) : window_len;
            stat_lost <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (!enable) begin
            state      <= IDLE;
            sample_cnt <= '0;
            acc_sum    <= '0;
            acc_max    <= '0;
            acc_ovf    <= '0;
            acc_empty  <= '0;
          end else if (sample_en) begin
            if (win_close) begin
              stat_sum    <= nxt_sum;
              stat_max    <= nxt_max;
              stat_ovf    <= nxt_ovf;
              stat_empty  <= nxt_empty;
              stats_valid <= 1'b1;
              if (stats_valid && !stats_ack) stat_lost <= 1'b1;
              // Restart with no dead time: the next sample opens the new window.
              sample_cnt  <= '0;
              acc_sum     <= '0;
              acc_max     <= '0;
              acc_ovf     <= '0;
              acc_empty   <= '0;
            end else begin
              sample_cnt <= sample_cnt + WIN_W'(1);
              acc_sum    <= nxt_sum;
              acc_max    <= nxt_max;
              acc_ovf    <= nxt_ovf;
              acc_empty  <= nxt_empty;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cluster_rate_monitor.sv
// Directed bench for cluster_rate_monitor: default instance plus an 8-bit-sum instance
// that shares the same stimulus to exercise accumulator saturation.
module tb_cluster_rate_monitor;

  logic        clock4x = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] window_len = 16'd0;
  logic        sample_en = 1'b0;
  logic [7:0]  cnt_in = 8'd0;
  logic        overflow_in = 1'b0;
  logic        stats_ack = 1'b0;

  logic        stats_valid, stat_lost, running;
  logic [23:0] stat_sum;
  logic [7:0]  stat_max;
  logic [15:0] stat_ovf, stat_empty;

  logic        s8_valid, s8_lost, s8_running;
  logic [7:0]  s8_sum;
  logic [7:0]  s8_max;
  logic [15:0] s8_ovf, s8_empty;

  int errors = 0;
  int checks = 0;

  always #5 clock4x = ~clock4x;

  cluster_rate_monitor dut (
    .clock4x(clock4x), .reset(reset), .enable(enable), .window_len(window_len),
    .sample_en(sample_en), .cnt_in(cnt_in), .overflow_in(overflow_in),
    .stats_valid(stats_valid), .stats_ack(stats_ack), .stat_sum(stat_sum),
    .stat_max(stat_max), .stat_ovf(stat_ovf), .stat_empty(stat_empty),
    .stat_lost(stat_lost), .running(running)
  );

  cluster_rate_monitor #(.SUM_W(8)) dut8 (
    .clock4x(clock4x), .reset(reset), .enable(enable), .window_len(window_len),
    .sample_en(sample_en), .cnt_in(cnt_in), .overflow_in(overflow_in),
    .stats_valid(s8_valid), .stats_ack(stats_ack), .stat_sum(s8_sum),
    .stat_max(s8_max), .stat_ovf(s8_ovf), .stat_empty(s8_empty),
    .stat_lost(s8_lost), .running(s8_running)
  );

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clock4x);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] c, input logic ovf);
    sample_en   = 1'b1;
    cnt_in      = c;
    overflow_in = ovf;
    cyc();
    sample_en   = 1'b0;
    cnt_in      = 8'd0;
    overflow_in = 1'b0;
  endtask

  task automatic restart(input logic [15:0] wl);
    enable = 1'b0;
    cyc();
    window_len = wl;
    enable = 1'b1;
    cyc();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    checks++;
    if (stats_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", stats_valid); end
    checks++;
    if (stat_sum !== 24'd0) begin errors++; $display("FAIL reset_sum: got %0d want 0", stat_sum); end
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", running); end
    checks++;
    if (stat_lost !== 1'b0) begin errors++; $display("FAIL reset_lost: got %b want 0", stat_lost); end
  endtask

  task automatic test_basic_window;
    window_len = 16'd4;
    enable = 1'b1;
    cyc();
    checks++;
    if (running !== 1'b1) begin errors++; $display("FAIL t1_running: got %b want 1", running); end
    send(8'd3, 1'b0);
    send(8'd0, 1'b0);
    send(8'd9, 1'b1);
    checks++;
    if (stats_valid !== 1'b0) begin errors++; $display("FAIL t1_early_valid: got %b want 0", stats_valid); end
    send(8'd2, 1'b0);
    checks++;
    if (stats_valid !== 1'b1) begin errors++; $display("FAIL t1_valid: got %b want 1", stats_valid); end
    checks++;
    if (stat_sum !== 24'd14) begin errors++; $display("FAIL t1_sum: got %0d want 14", stat_sum); end
    checks++;
    if (stat_max !== 8'd9) begin errors++; $display("FAIL t1_max: got %0d want 9", stat_max); end
    checks++;
    if (stat_ovf !== 16'd1) begin errors++; $display("FAIL t1_ovf: got %0d want 1", stat_ovf); end
    checks++;
    if (stat_empty !== 16'd1) begin errors++; $display("FAIL t1_empty: got %0d want 1", stat_empty); end
    stats_ack = 1'b1;
    cyc();
    stats_ack = 1'b0;
    checks++;
    if (stats_valid !== 1'b0) begin errors++; $display("FAIL t1_ack: got %b want 0", stats_valid); end
  endtask

  task automatic test_overwrite;
    restart(16'd2);
    send(8'd1, 1'b0); cyc(3);
    send(8'd2, 1'b0);
    checks++;
    if (stat_sum !== 24'd3) begin errors++; $display("FAIL t2_first_sum: got %0d want 3", stat_sum); end
    checks++;
    if (stat_lost !== 1'b0) begin errors++; $display("FAIL t2_first_lost: got %b want 0", stat_lost); end
    cyc(3);
    send(8'd4, 1'b0); cyc(3);
    send(8'd5, 1'b0);
    checks++;
    if (stat_sum !== 24'd9) begin errors++; $display("FAIL t2_second_sum: got %0d want 9", stat_sum); end
    checks++;
    if (stat_lost !== 1'b1) begin errors++; $display("FAIL t2_lost: got %b want 1", stat_lost); end
    checks++;
    if (stats_valid !== 1'b1) begin errors++; $display("FAIL t2_valid: got %b want 1", stats_valid); end
    stats_ack = 1'b1;
    cyc();
    stats_ack = 1'b0;
    checks++;
    if (stats_valid !== 1'b0) begin errors++; $display("FAIL t2_ack: got %b want 0", stats_valid); end
    checks++;
    if (stat_lost !== 1'b1) begin errors++; $display("FAIL t2_lost_sticky: got %b want 1", stat_lost); end
  endtask

  task automatic test_abort;
    restart(16'd5);
    send(8'd7, 1'b0);
    send(8'd7, 1'b0);
    send(8'd7, 1'b0);
    enable = 1'b0;
    cyc();
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL t4_stopped: got %b want 0", running); end
    checks++;
    if (stats_valid !== 1'b0) begin errors++; $display("FAIL t4_no_valid: got %b want 0", stats_valid); end
    enable = 1'b1;
    cyc();
    checks++;
    if (stat_lost !== 1'b0) begin errors++; $display("FAIL t4_lost_clear: got %b want 0", stat_lost); end
    for (int i = 0; i < 5; i++) send(8'd1, 1'b0);
    checks++;
    if (stats_valid !== 1'b1) begin errors++; $display("FAIL t4_valid: got %b want 1", stats_valid); end
    checks++;
    if (stat_sum !== 24'd5) begin errors++; $display("FAIL t4_sum: got %0d want 5", stat_sum); end
    checks++;
    if (stat_max !== 8'd1) begin errors++; $display("FAIL t4_max: got %0d want 1", stat_max); end
    stats_ack = 1'b1;
    cyc();
    stats_ack = 1'b0;
  endtask

  task automatic test_back_to_back;
    restart(16'd0);
    send(8'd3, 1'b0);
    checks++;
    if (stat_sum !== 24'd3) begin errors++; $display("FAIL t5_len0_sum: got %0d want 3", stat_sum); end
    stats_ack = 1'b1;
    send(8'd6, 1'b0);
    stats_ack = 1'b0;
    checks++;
    if (stats_valid !== 1'b1) begin errors++; $display("FAIL t5_ack_close_valid: got %b want 1", stats_valid); end
    checks++;
    if (stat_sum !== 24'd6) begin errors++; $display("FAIL t5_ack_close_sum: got %0d want 6", stat_sum); end
    checks++;
    if (stat_lost !== 1'b0) begin errors++; $display("FAIL t5_ack_close_lost: got %b want 0", stat_lost); end
    send(8'd0, 1'b0);
    checks++;
    if (stat_empty !== 16'd1) begin errors++; $display("FAIL t5_empty: got %0d want 1", stat_empty); end
    checks++;
    if (stat_lost !== 1'b1) begin errors++; $display("FAIL t5_lost: got %b want 1", stat_lost); end
  endtask

  task automatic test_saturation;
    restart(16'd40);
    stats_ack = 1'b1;
    cyc();
    stats_ack = 1'b0;
    for (int i = 0; i < 40; i++) send(8'd8, 1'b0);
    checks++;
    if (s8_valid !== 1'b1) begin errors++; $display("FAIL t3_valid: got %b want 1", s8_valid); end
    checks++;
    if (s8_sum !== 8'd255) begin errors++; $display("FAIL t3_sat_sum: got %0d want 255", s8_sum); end
    checks++;
    if (s8_max !== 8'd8) begin errors++; $display("FAIL t3_max: got %0d want 8", s8_max); end
    checks++;
    if (stat_sum !== 24'd320) begin errors++; $display("FAIL t3_wide_sum: got %0d want 320", stat_sum); end
  endtask

  task automatic test_reset_mid_window;
    send(8'd2, 1'b1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    enable = 1'b0;
    checks++;
    if (stats_valid !== 1'b0) begin errors++; $display("FAIL t6_valid: got %b want 0", stats_valid); end
    checks++;
    if (stat_sum !== 24'd0) begin errors++; $display("FAIL t6_sum: got %0d want 0", stat_sum); end
    checks++;
    if (stat_max !== 8'd0) begin errors++; $display("FAIL t6_max: got %0d want 0", stat_max); end
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL t6_running: got %b want 0", running); end
    checks++;
    if (s8_sum !== 8'd0) begin errors++; $display("FAIL t6_s8_sum: got %0d want 0", s8_sum); end
    cyc();
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL t6_stays_idle: got %b want 0", running); end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic_window();
    test_overwrite();
    test_abort();
    test_back_to_back();
    test_saturation();
    test_reset_mid_window();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
